// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random-number bank: game-state codes,
// default tap mask and seed, and the seed rotation helper.
package lfsr_pkg;

    localparam logic [1:0] IDLE           = 2'b00;
    localparam logic [1:0] OPENING_SCREEN = 2'b01;
    localparam logic [1:0] GAME_RUNNING   = 2'b10;
    localparam logic [1:0] GAME_OVER      = 2'b11;

    localparam logic [31:0] DEF_TAPS = 32'h10244220;
    localparam logic [31:0] DEF_SEED = 32'h0000ACE1;

    // Rotate the low w bits of v left by n; bits at and above w come back zero.
    // Channels are decorrelated by rotating the common seed by 8*k.
    function automatic logic [63:0] rotl(input logic [63:0] v, input int w, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < w) r[(i + n) % w] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr_channel.sv
// Single Fibonacci LFSR channel with load, advance and hold.
// With LFSR_LOCKUP_GUARD_EN defined, an all-zero state is replaced by the
// channel's reset seed on the next edge unless a load takes precedence.
module lfsr_channel
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] RST_SEED = WIDTH'(DEF_SEED)
) (
    input  logic             game_clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             advance,
`ifdef LFSR_LOCKUP_GUARD_EN
    output logic             zero,
`endif
    output logic [WIDTH-1:0] state
);

    logic fb;

    assign fb = ^(state & TAPS);

`ifdef LFSR_LOCKUP_GUARD_EN
    assign zero = (state == '0);
`endif

    // State register: reset > load > (guard reload) > advance > hold.
    always_ff @(posedge game_clk or negedge rst) begin
        if (!rst) begin
            state <= RST_SEED;
        end else if (load) begin
            state <= load_val;
`ifdef LFSR_LOCKUP_GUARD_EN
        end else if (zero) begin
            state <= RST_SEED;
`endif
        end else if (advance) begin
            state <= {state[WIDTH-2:0], fb};
        end
    end

endmodule

// File: rtl/lfsr_rng_bank.sv
// Bank of NUM_CH independent LFSRs advancing while the game runs, with
// runtime reseed and a registered bounded-range request port.
// Optional build macro: LFSR_LOCKUP_GUARD_EN adds all-zero recovery and the
// lockup pulse output.
module lfsr_rng_bank
    import lfsr_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] TAPS    = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED    = WIDTH'(DEF_SEED),
    parameter int               NUM_CH  = 4,
    parameter int               RANGE_W = 8,
    parameter int               CH_W    = 2
) (
    input  logic                    rst,
    input  logic                    game_clk,
    input  logic [1:0]              game_state_w,
    input  logic                    seed_load,
    input  logic [WIDTH-1:0]        seed_in,
    output logic [NUM_CH*WIDTH-1:0] random_number,
    input  logic                    req_valid,
    input  logic [CH_W-1:0]         req_ch,
    input  logic [RANGE_W-1:0]      req_max,
    output logic                    resp_valid,
    output logic [RANGE_W-1:0]      resp_data
`ifdef LFSR_LOCKUP_GUARD_EN
    ,
    output logic                    lockup
`endif
);

    logic [WIDTH-1:0]     seed_sel;
    logic                 advance;
    logic [RANGE_W-1:0]   st_top [NUM_CH];
    logic [RANGE_W-1:0]   top_sel;
    logic [RANGE_W:0]     span;
    logic [2*RANGE_W:0]   prod;
    logic [RANGE_W-1:0]   scaled;
`ifdef LFSR_LOCKUP_GUARD_EN
    logic [NUM_CH-1:0]    zero_vec;
`endif

    // A zero reseed value would lock the LFSRs, so it falls back to SEED.
    assign seed_sel = (seed_in != '0) ? seed_in : SEED;
    assign advance  = (game_state_w == GAME_RUNNING);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam int ROT = (8 * k) % WIDTH;
        logic [WIDTH-1:0] load_val;
        logic [WIDTH-1:0] ch_state;

        assign load_val = WIDTH'(rotl(64'(seed_sel), WIDTH, ROT));

        lfsr_channel #(
            .WIDTH    (WIDTH),
            .TAPS     (TAPS),
            .RST_SEED (WIDTH'(rotl(64'(SEED), WIDTH, ROT)))
        ) u_ch (
            .game_clk (game_clk),
            .rst      (rst),
            .load     (seed_load),
            .load_val (load_val),
            .advance  (advance),
`ifdef LFSR_LOCKUP_GUARD_EN
            .zero     (zero_vec[k]),
`endif
            .state    (ch_state)
        );

        assign random_number[k*WIDTH +: WIDTH] = ch_state;
        assign st_top[k] = ch_state[WIDTH-1 -: RANGE_W];
    end

    // Out-of-range channel indices fall back to channel 0. The product is one
    // bit wider than twice RANGE_W so req_max = all-ones cannot overflow.
    assign top_sel = (int'(req_ch) < NUM_CH) ? st_top[req_ch] : st_top[0];
    assign span    = {1'b0, req_max} + 1'b1;
    assign prod    = {{(RANGE_W+1){1'b0}}, top_sel} * {{RANGE_W{1'b0}}, span};
    assign scaled  = RANGE_W'(prod >> RANGE_W);

    // Response register: one-cycle strobe per request, data holds between.
    always_ff @(posedge game_clk or negedge rst) begin
        if (!rst) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= req_valid;
            if (req_valid) resp_data <= scaled;
        end
    end

`ifdef LFSR_LOCKUP_GUARD_EN
    // Lockup pulse accompanies the guard reload; a reseed masks the reload.
    always_ff @(posedge game_clk or negedge rst) begin
        if (!rst) lockup <= 1'b0;
        else      lockup <= (|zero_vec) & ~seed_load;
    end
`endif

endmodule

// File: tb/tb_lfsr_rng_bank.sv
// Self-checking bench for lfsr_rng_bank: a behavioural model of the channel
// states and range port is checked on every falling edge, plus literal
// expectations for known values.
module tb_lfsr_rng_bank;

    localparam logic [31:0] TAPS = 32'h10244220;
    localparam logic [31:0] SEED = 32'h0000ACE1;
`ifdef LFSR_LOCKUP_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic         rst;
    logic         game_clk;
    logic [1:0]   game_state_w;
    logic         seed_load;
    logic [31:0]  seed_in;
    logic [127:0] random_number;
    logic         req_valid;
    logic [1:0]   req_ch;
    logic [7:0]   req_max;
    logic         resp_valid;
    logic [7:0]   resp_data;
    logic         lockup;

    lfsr_rng_bank dut (
        .rst           (rst),
        .game_clk      (game_clk),
        .game_state_w  (game_state_w),
        .seed_load     (seed_load),
        .seed_in       (seed_in),
        .random_number (random_number),
        .req_valid     (req_valid),
        .req_ch        (req_ch),
        .req_max       (req_max),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data)
`ifdef LFSR_LOCKUP_GUARD_EN
        ,
        .lockup        (lockup)
`endif
    );

`ifndef LFSR_LOCKUP_GUARD_EN
    assign lockup = 1'b0;
`endif

    initial game_clk = 1'b0;
    always #5 game_clk = ~game_clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rot(input logic [31:0] v, input int n);
        if (n == 0) return v;
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], 1'($countones(v & TAPS) % 2)};
    endfunction

    // Behavioural model
    logic [31:0] m_state [4];
    logic        exp_rv;
    logic [7:0]  exp_rd;
    logic        exp_lk;

    always @(posedge game_clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) m_state[k] = rot(SEED, 8 * k);
            exp_rv = 1'b0;
            exp_rd = 8'd0;
            exp_lk = 1'b0;
        end else begin
            logic any_zero;
            logic [31:0] s;
            exp_rv = req_valid;
            if (req_valid) exp_rd = 8'((int'(m_state[req_ch] >> 24) * (int'(req_max) + 1)) / 256);
            any_zero = 1'b0;
            for (int k = 0; k < 4; k++) if (m_state[k] == 32'd0) any_zero = 1'b1;
            exp_lk = GUARD && any_zero && !seed_load;
            s = (seed_in != 32'd0) ? seed_in : SEED;
            for (int k = 0; k < 4; k++) begin
                if (seed_load)                          m_state[k] = rot(s, 8 * k);
                else if (GUARD && m_state[k] == 32'd0)  m_state[k] = rot(SEED, 8 * k);
                else if (game_state_w == 2'b10)         m_state[k] = lfsr_step(m_state[k]);
            end
        end
    end

    // Compare process
    always @(negedge game_clk) begin
        if (started && rst) begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("ch%0d_state", k), 64'(random_number[k*32 +: 32]), 64'(m_state[k]));
            chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
            chk("resp_data", 64'(resp_data), 64'(exp_rd));
            chk("lockup", 64'(lockup), 64'(exp_lk));
        end
    end

    task automatic tick();
        @(negedge game_clk);
    endtask

    initial begin
        rst = 1'b1; game_state_w = 2'b00; seed_load = 1'b0; seed_in = 32'd0;
        req_valid = 1'b0; req_ch = 2'd0; req_max = 8'd0;
        #3 rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        started = 1'b1;

        // Idle: all channels hold reset seeds
        repeat (10) tick();
        chk("lit_ch0_reset", 64'(random_number[31:0]),   64'h0000ACE1);
        chk("lit_ch1_reset", 64'(random_number[63:32]),  64'h00ACE100);
        chk("lit_ch3_reset", 64'(random_number[127:96]), 64'hE10000AC);

        // Range requests from ch3 (top byte 0xE1 = 225)
        req_valid = 1'b1; req_ch = 2'd3; req_max = 8'd9;
        tick();
        chk("lit_range_max9", 64'(resp_data), 64'd8);
        chk("lit_range_rv", 64'(resp_valid), 64'd1);
        req_max = 8'd255;
        tick();
        chk("lit_range_max255", 64'(resp_data), 64'd225);
        req_valid = 1'b0;
        tick();
        chk("lit_rv_drop", 64'(resp_valid), 64'd0);
        chk("lit_rd_hold", 64'(resp_data), 64'd225);

        // One running edge, then game over holds
        game_state_w = 2'b10;
        tick();
        chk("lit_ch0_step", 64'(random_number[31:0]), 64'h000159C3);
        game_state_w = 2'b11;
        repeat (3) tick();
        chk("lit_ch0_hold", 64'(random_number[31:0]), 64'h000159C3);
        game_state_w = 2'b01;
        tick();

        // Run, then reseed with zero (falls back to SEED) while running
        game_state_w = 2'b10;
        repeat (5) tick();
        seed_load = 1'b1; seed_in = 32'd0;
        tick();
        chk("lit_reseed0_ch0", 64'(random_number[31:0]),  64'h0000ACE1);
        chk("lit_reseed0_ch2", 64'(random_number[95:64]), 64'hACE10000);
        seed_in = 32'd1;
        tick();
        chk("lit_reseed1_ch0", 64'(random_number[31:0]),  64'h00000001);
        chk("lit_reseed1_ch1", 64'(random_number[63:32]), 64'h00000100);
        seed_load = 1'b0;

        // Back-to-back requests while running, including one with a reseed
        for (int i = 0; i < 12; i++) begin
            req_valid = 1'b1;
            req_ch    = 2'(i);
            req_max   = 8'(i * 23 + 5);
            seed_load = (i == 7);
            seed_in   = 32'h1234_5678;
            tick();
        end
        seed_load = 1'b0;
        req_valid = 1'b0;
        repeat (20) tick();

        // Reset mid-stream drops the pending response
        req_valid = 1'b1; req_ch = 2'd1; req_max = 8'd100;
        tick();
        req_valid = 1'b1;
        @(posedge game_clk);
        #2 rst = 1'b0;
        #1;
        chk("lit_rst_rv", 64'(resp_valid), 64'd0);
        chk("lit_rst_ch0", 64'(random_number[31:0]), 64'h0000ACE1);
        req_valid = 1'b0;
        game_state_w = 2'b00;
        tick();
        rst = 1'b1;
        tick();

        // Force ch2 to zero while idle
        #2 force dut.g_ch[2].u_ch.state = 32'd0;
        #1 release dut.g_ch[2].u_ch.state;
        m_state[2] = 32'd0;
        tick();
        if (GUARD) begin
            chk("lit_guard_ch2", 64'(random_number[95:64]), 64'hACE10000);
            chk("lit_guard_lockup", 64'(lockup), 64'd1);
            tick();
            chk("lit_guard_lockup_end", 64'(lockup), 64'd0);
        end else begin
            chk("lit_noguard_ch2", 64'(random_number[95:64]), 64'd0);
            game_state_w = 2'b10;
            repeat (5) tick();
            chk("lit_noguard_ch2_run", 64'(random_number[95:64]), 64'd0);
        end
        game_state_w = 2'b10;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
